// File: rtl/teclado_bcd_param.sv
// Clocked 4x4 keypad front end: debounces one-hot row/column samples, accepts each press once,
// accumulates BCD digits into an NDIG-digit entry buffer and publishes it on Enter.
module teclado_bcd_param #(
  parameter int NDIG       = 3,
  parameter int DEB_CYCLES = 4,
  parameter int OVF_MODE   = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [3:0]                  lin,
  input  logic [3:0]                  col,
  input  logic                        bot_press,
  output logic [4*NDIG-1:0]           s,
  output logic                        s_valid,
  output logic [4*NDIG-1:0]           entrada,
  output logic [$clog2(NDIG+1)-1:0]   n_dig,
  output logic                        overflow
);

  localparam int W  = 4 * NDIG;
  localparam int NW = $clog2(NDIG + 1);
  localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam logic [NW-1:0] NDIG_C = NW'(NDIG);
  localparam logic [CW-1:0] DEB_C  = CW'(DEB_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEB  = 2'd1,
    ST_HELD = 2'd2,
    ST_REL  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    K_NONE  = 3'd0,
    K_DIGIT = 3'd1,
    K_ENTER = 3'd2,
    K_CLEAR = 3'd3,
    K_BACK  = 3'd4
  } kind_t;

  function automatic logic onehot4(input logic [3:0] v);
    return (v == 4'b1000) || (v == 4'b0100) || (v == 4'b0010) || (v == 4'b0001);
  endfunction

  state_t          state_r, state_nx_s;
  logic [CW-1:0]   cnt_r, cnt_nx_s, cnt_inc_s;
  logic [7:0]      key_r, key_nx_s, sample_s;
  logic            valid_s, commit_s;
  kind_t           kind_s;
  logic [3:0]      digit_s;
  logic [W-1:0]    s_r, entrada_r, ent_shift_s;
  logic [W+3:0]    ent_wide_s;
  logic [NW-1:0]   n_dig_r;
  logic            s_valid_r, overflow_r;

  assign sample_s    = {lin, col};
  assign valid_s     = bot_press && onehot4(lin) && onehot4(col);
  assign cnt_inc_s   = cnt_r + CW'(1);
  assign ent_wide_s  = {entrada_r, digit_s};
  assign ent_shift_s = ent_wide_s[W-1:0];

  // Key map decode of the live sample (letter column keys other than D decode to K_NONE)
  always_comb begin
    kind_s  = K_NONE;
    digit_s = 4'd0;
    case (sample_s)
      8'h88: begin kind_s = K_DIGIT; digit_s = 4'd1; end
      8'h84: begin kind_s = K_DIGIT; digit_s = 4'd2; end
      8'h82: begin kind_s = K_DIGIT; digit_s = 4'd3; end
      8'h48: begin kind_s = K_DIGIT; digit_s = 4'd4; end
      8'h44: begin kind_s = K_DIGIT; digit_s = 4'd5; end
      8'h42: begin kind_s = K_DIGIT; digit_s = 4'd6; end
      8'h28: begin kind_s = K_DIGIT; digit_s = 4'd7; end
      8'h24: begin kind_s = K_DIGIT; digit_s = 4'd8; end
      8'h22: begin kind_s = K_DIGIT; digit_s = 4'd9; end
      8'h14: begin kind_s = K_DIGIT; digit_s = 4'd0; end
      8'h12: kind_s = K_ENTER;
      8'h18: kind_s = K_CLEAR;
      8'h11: kind_s = K_BACK;
      default: kind_s = K_NONE;
    endcase
  end

  // Debounce FSM next state; commit_s marks the edge where the press is accepted
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    key_nx_s   = key_r;
    commit_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (valid_s) begin
          key_nx_s = sample_s;
          if (DEB_C == CW'(1)) begin
            commit_s   = 1'b1;
            state_nx_s = ST_HELD;
            cnt_nx_s   = CW'(0);
          end else begin
            state_nx_s = ST_DEB;
            cnt_nx_s   = CW'(1);
          end
        end else begin
          state_nx_s = ST_IDLE;
          cnt_nx_s   = CW'(0);
        end
      end
      ST_DEB: begin
        if (valid_s && (sample_s == key_r)) begin
          if (cnt_inc_s == DEB_C) begin
            commit_s   = 1'b1;
            state_nx_s = ST_HELD;
            cnt_nx_s   = CW'(0);
          end else begin
            cnt_nx_s = cnt_inc_s;
          end
        end else begin
          state_nx_s = ST_IDLE;
          cnt_nx_s   = CW'(0);
        end
      end
      ST_HELD: begin
        if (!bot_press) begin
          if (DEB_C == CW'(1)) begin
            state_nx_s = ST_IDLE;
            cnt_nx_s   = CW'(0);
          end else begin
            state_nx_s = ST_REL;
            cnt_nx_s   = CW'(1);
          end
        end else begin
          state_nx_s = ST_HELD;
        end
      end
      ST_REL: begin
        if (bot_press) begin
          state_nx_s = ST_HELD;
          cnt_nx_s   = CW'(0);
        end else if (cnt_inc_s == DEB_C) begin
          state_nx_s = ST_IDLE;
          cnt_nx_s   = CW'(0);
        end else begin
          cnt_nx_s = cnt_inc_s;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        cnt_nx_s   = CW'(0);
      end
    endcase
  end

  // Debounce state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= CW'(0);
      key_r   <= 8'd0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      key_r   <= key_nx_s;
    end
  end

  // Entry buffer and committed value; pulses default low every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_r        <= '0;
      entrada_r  <= '0;
      n_dig_r    <= '0;
      s_valid_r  <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      s_valid_r  <= 1'b0;
      overflow_r <= 1'b0;
      if (commit_s) begin
        case (kind_s)
          K_DIGIT: begin
            if (n_dig_r != NDIG_C) begin
              entrada_r <= ent_shift_s;
              n_dig_r   <= n_dig_r + NW'(1);
            end else begin
              overflow_r <= 1'b1;
              if (OVF_MODE != 0) begin
                entrada_r <= ent_shift_s;
              end
            end
          end
          K_ENTER: begin
            if (n_dig_r != NW'(0)) begin
              s_r       <= entrada_r;
              s_valid_r <= 1'b1;
              entrada_r <= '0;
              n_dig_r   <= '0;
            end
          end
          K_CLEAR: begin
            entrada_r <= '0;
            n_dig_r   <= '0;
          end
          K_BACK: begin
            if (n_dig_r != NW'(0)) begin
              entrada_r <= entrada_r >> 4;
              n_dig_r   <= n_dig_r - NW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign s        = s_r;
  assign s_valid  = s_valid_r;
  assign entrada  = entrada_r;
  assign n_dig    = n_dig_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_teclado_bcd_param.sv
// Bench for teclado_bcd_param: keypad press sequences with a scoreboard of expected
// committed values, plus a second instance built with the shift-out overflow policy.
module tb_teclado_bcd_param;

  localparam int K_ENT = 10;
  localparam int K_CLR = 11;
  localparam int K_BS  = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  lin = 4'd0;
  logic [3:0]  col = 4'd0;
  logic        bot_press = 1'b0;
  logic [11:0] s0, entrada0, s1, entrada1;
  logic        s_valid0, overflow0, s_valid1, overflow1;
  logic [1:0]  n_dig0, n_dig1;

  int total = 0;
  int bad = 0;
  int ovf_cnt = 0;
  logic sv_prev = 1'b0;
  logic [11:0] sb[$];

  teclado_bcd_param #(.NDIG(3), .DEB_CYCLES(4), .OVF_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .lin(lin), .col(col), .bot_press(bot_press),
    .s(s0), .s_valid(s_valid0), .entrada(entrada0), .n_dig(n_dig0), .overflow(overflow0));

  teclado_bcd_param #(.NDIG(3), .DEB_CYCLES(4), .OVF_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .lin(lin), .col(col), .bot_press(bot_press),
    .s(s1), .s_valid(s_valid1), .entrada(entrada1), .n_dig(n_dig1), .overflow(overflow1));

  always #5 clk = ~clk;

  function automatic logic [7:0] key_lc(input int k);
    case (k)
      0: return 8'h14;  1: return 8'h88;  2: return 8'h84;  3: return 8'h82;
      4: return 8'h48;  5: return 8'h44;  6: return 8'h42;  7: return 8'h28;
      8: return 8'h24;  9: return 8'h22;  10: return 8'h12; 11: return 8'h18;
      12: return 8'h11;
      default: return 8'h00;
    endcase
  endfunction

  // Scoreboard: every s_valid pops one expected value; pulses must be single-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_valid0) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected s_valid with s=%h, nothing expected", s0);
        end else begin
          logic [11:0] exp_v;
          exp_v = sb.pop_front();
          if (s0 !== exp_v) begin
            bad++;
            $display("FAIL sb_value s=%h expected %h", s0, exp_v);
          end
        end
        total++;
        if (sv_prev) begin
          bad++;
          $display("FAIL s_valid_width high two cycles, got 1 expected 0");
        end
      end
      if (overflow0) ovf_cnt++;
      sv_prev = s_valid0;
    end else begin
      sv_prev = 1'b0;
    end
  end

  task automatic press(input int k, input int hold, input int rel);
    @(posedge clk); #1;
    {lin, col} = key_lc(k);
    bot_press = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    bot_press = 1'b0;
    lin = 4'd0;
    col = 4'd0;
    repeat (rel) @(posedge clk);
  endtask

  task automatic key(input int k);
    press(k, 6, 6);
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({s0, s_valid0, entrada0, n_dig0, overflow0} !== 28'd0) begin
      bad++;
      $display("FAIL reset_outputs got s=%h v=%b e=%h n=%0d o=%b expected all 0",
               s0, s_valid0, entrada0, n_dig0, overflow0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_entry;
    key(2); key(6);
    @(negedge clk);
    total++;
    if (entrada0 !== 12'h026 || n_dig0 !== 2'd2) begin
      bad++;
      $display("FAIL entry_partial entrada=%h n=%0d expected 026 n=2", entrada0, n_dig0);
    end
    key(7);
    sb.push_back(12'h267);
    key(K_ENT);
    @(negedge clk);
    total++;
    if (s0 !== 12'h267 || entrada0 !== 12'h000 || n_dig0 !== 2'd0) begin
      bad++;
      $display("FAIL basic_enter s=%h entrada=%h n=%0d expected 267 000 0", s0, entrada0, n_dig0);
    end
  endtask

  task automatic test_bounce;
    press(5, 3, 6);
    @(negedge clk);
    total++;
    if (n_dig0 !== 2'd0) begin
      bad++;
      $display("FAIL bounce_short n_dig=%0d expected 0", n_dig0);
    end
    @(posedge clk); #1;
    lin = 4'b1100; col = 4'b1000; bot_press = 1'b1;
    repeat (8) @(posedge clk);
    #1 bot_press = 1'b0; lin = 4'd0; col = 4'd0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    total++;
    if (n_dig0 !== 2'd0 || entrada0 !== 12'h000) begin
      bad++;
      $display("FAIL bounce_glitch n_dig=%0d entrada=%h expected 0 000", n_dig0, entrada0);
    end
  endtask

  task automatic test_overflow;
    int ovf_before;
    ovf_before = ovf_cnt;
    key(4); key(9); key(3); key(1);
    total++;
    if (ovf_cnt - ovf_before !== 1) begin
      bad++;
      $display("FAIL ovf_pulse count=%0d expected 1", ovf_cnt - ovf_before);
    end
    sb.push_back(12'h493);
    key(K_ENT);
    @(negedge clk);
    total++;
    if (s0 !== 12'h493) begin
      bad++;
      $display("FAIL ovf_drop s=%h expected 493", s0);
    end
    total++;
    if (s1 !== 12'h931) begin
      bad++;
      $display("FAIL ovf_shift s=%h expected 931", s1);
    end
  endtask

  task automatic test_backspace;
    key(0); key(5); key(K_BS);
    @(negedge clk);
    total++;
    if (entrada0 !== 12'h000 || n_dig0 !== 2'd1) begin
      bad++;
      $display("FAIL backspace entrada=%h n=%0d expected 000 n=1", entrada0, n_dig0);
    end
    key(8);
    sb.push_back(12'h008);
    key(K_ENT);
    key(K_ENT);
    @(negedge clk);
    total++;
    if (s0 !== 12'h008) begin
      bad++;
      $display("FAIL empty_enter s=%h expected 008", s0);
    end
  endtask

  task automatic test_hold_and_clear;
    press(2, 60, 6);
    @(negedge clk);
    total++;
    if (n_dig0 !== 2'd1 || entrada0 !== 12'h002) begin
      bad++;
      $display("FAIL no_repeat n=%0d entrada=%h expected 1 002", n_dig0, entrada0);
    end
    sb.push_back(12'h002);
    key(K_ENT);
    key(3); key(4); key(K_CLR);
    @(negedge clk);
    total++;
    if (entrada0 !== 12'h000 || n_dig0 !== 2'd0 || s0 !== 12'h002) begin
      bad++;
      $display("FAIL clear entrada=%h n=%0d s=%h expected 000 0 002", entrada0, n_dig0, s0);
    end
  endtask

  task automatic test_reset_mid_entry;
    key(7); key(8);
    @(posedge clk); #1;
    {lin, col} = key_lc(9);
    bot_press = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({s0, s_valid0, entrada0, n_dig0, overflow0} !== 28'd0) begin
      bad++;
      $display("FAIL reset_mid got s=%h e=%h n=%0d expected all 0", s0, entrada0, n_dig0);
    end
    bot_press = 1'b0; lin = 4'd0; col = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    key(1);
    sb.push_back(12'h001);
    key(K_ENT);
    @(negedge clk);
    total++;
    if (s0 !== 12'h001) begin
      bad++;
      $display("FAIL after_reset s=%h expected 001", s0);
    end
  endtask

  initial begin
    test_reset;
    test_basic_entry;
    test_bounce;
    test_overflow;
    test_backspace;
    test_hold_and_clear;
    test_reset_mid_entry;
    repeat (4) @(posedge clk);
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain pending=%0d expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
